// File: rtl/macguffin_pkg.sv
// Shared constants and types for the MacGuffin cipher block and its
// stream arbiter.
package macguffin_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int ROUND_NUM  = 32;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Single valid wins; on a tie the requester that did not go last wins.
  function automatic req_id_t rr_pick(
    input logic    v0,
    input logic    v1,
    input req_id_t last
  );
    req_id_t g;
    g = ~last;
    if (v0 && !v1) g = REQ0;
    if (v1 && !v0) g = REQ1;
    return g;
  endfunction

endpackage

// File: rtl/macguffin_tag_fifo.sv
// Show-ahead FIFO of requester IDs, one entry per block in the core.
// Depth need not be a power of two; pointers wrap explicitly.
module macguffin_tag_fifo
  import macguffin_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  req_id_t                    din,
  output req_id_t                    dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  req_id_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/macguffin_stream_arbiter.sv
// Round-robin sharing of one in-order MacGuffin core between two
// AXI4-Stream requesters; results are steered back by a tag FIFO.
module macguffin_stream_arbiter #(
  parameter int BLOCK_SIZE = macguffin_pkg::BLOCK_SIZE,
  parameter int TAG_DEPTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BLOCK_SIZE-1:0]          s0_axis_tdata,
  input  logic                           s0_axis_tvalid,
  output logic                           s0_axis_tready,
  input  logic [BLOCK_SIZE-1:0]          s1_axis_tdata,
  input  logic                           s1_axis_tvalid,
  output logic                           s1_axis_tready,
  output logic [BLOCK_SIZE-1:0]          c_m_axis_tdata,
  output logic                           c_m_axis_tvalid,
  input  logic                           c_m_axis_tready,
  input  logic [BLOCK_SIZE-1:0]          c_s_axis_tdata,
  input  logic                           c_s_axis_tvalid,
  output logic                           c_s_axis_tready,
  output logic [BLOCK_SIZE-1:0]          m0_axis_tdata,
  output logic                           m0_axis_tvalid,
  input  logic                           m0_axis_tready,
  output logic [BLOCK_SIZE-1:0]          m1_axis_tdata,
  output logic                           m1_axis_tvalid,
  input  logic                           m1_axis_tready,
  output logic [$clog2(TAG_DEPTH+1)-1:0] tag_count,
  output logic                           err_orphan
);

  import macguffin_pkg::*;

  req_id_t r_rr_last;
  req_id_t r_grant_q;
  logic    r_lock;
  logic    r_orphan;

  req_id_t w_grant;
  req_id_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_can;
  logic    w_sv;
  logic    w_push;
  logic    w_pop;
  logic    w_mrdy;

  macguffin_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_grant),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (tag_count)
  );

  // Outputs are gated by rst_n so every valid/ready is low during reset.
  always_comb begin
    w_grant = r_lock ? r_grant_q
                     : rr_pick(s0_axis_tvalid, s1_axis_tvalid, r_rr_last);
    w_can   = rst_n && !w_full;
    w_sv    = (w_grant == REQ1) ? s1_axis_tvalid : s0_axis_tvalid;
    w_mrdy  = (w_head == REQ1) ? m1_axis_tready : m0_axis_tready;
  end

  assign c_m_axis_tvalid = w_can && w_sv;
  assign c_m_axis_tdata  = (w_grant == REQ1) ? s1_axis_tdata
                                             : s0_axis_tdata;
  assign s0_axis_tready  = w_can && c_m_axis_tready && (w_grant == REQ0);
  assign s1_axis_tready  = w_can && c_m_axis_tready && (w_grant == REQ1);
  assign w_push          = c_m_axis_tvalid && c_m_axis_tready;

  assign m0_axis_tdata   = c_s_axis_tdata;
  assign m1_axis_tdata   = c_s_axis_tdata;
  assign m0_axis_tvalid  = rst_n && !w_empty && (w_head == REQ0)
                           && c_s_axis_tvalid;
  assign m1_axis_tvalid  = rst_n && !w_empty && (w_head == REQ1)
                           && c_s_axis_tvalid;
  assign c_s_axis_tready = rst_n && (w_empty || w_mrdy);
  assign w_pop           = !w_empty && c_s_axis_tvalid && c_s_axis_tready;
  assign err_orphan      = r_orphan;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_last <= REQ1;
      r_grant_q <= REQ0;
      r_lock    <= 1'b0;
      r_orphan  <= 1'b0;
    end else begin
      if (w_push) begin
        r_lock    <= 1'b0;
        r_rr_last <= w_grant;
      end else if (c_m_axis_tvalid && !c_m_axis_tready) begin
        r_lock    <= 1'b1;
        r_grant_q <= w_grant;
      end
      if (w_empty && c_s_axis_tvalid) r_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_macguffin_stream_arbiter.sv
// Directed bench for macguffin_stream_arbiter; the bench plays the
// core and both requesters, with a 4-entry tag FIFO.
module tb_macguffin_stream_arbiter;

  localparam int BS = 64;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BS-1:0] s0_d, s1_d, cm_d, cs_d, m0_d, m1_d;
  logic          s0_v, s0_r, s1_v, s1_r;
  logic          cm_v, cm_r, cs_v, cs_r;
  logic          m0_v, m0_r, m1_v, m1_r;
  logic [2:0]    cnt;
  logic          orphan;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  macguffin_stream_arbiter #(
    .BLOCK_SIZE (BS),
    .TAG_DEPTH  (TD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s0_axis_tdata   (s0_d),
    .s0_axis_tvalid  (s0_v),
    .s0_axis_tready  (s0_r),
    .s1_axis_tdata   (s1_d),
    .s1_axis_tvalid  (s1_v),
    .s1_axis_tready  (s1_r),
    .c_m_axis_tdata  (cm_d),
    .c_m_axis_tvalid (cm_v),
    .c_m_axis_tready (cm_r),
    .c_s_axis_tdata  (cs_d),
    .c_s_axis_tvalid (cs_v),
    .c_s_axis_tready (cs_r),
    .m0_axis_tdata   (m0_d),
    .m0_axis_tvalid  (m0_v),
    .m0_axis_tready  (m0_r),
    .m1_axis_tdata   (m1_d),
    .m1_axis_tvalid  (m1_v),
    .m1_axis_tready  (m1_r),
    .tag_count       (cnt),
    .err_orphan      (orphan)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; checks happen 1ns later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s0_v = 1'b1; s1_v = 1'b1; cm_r = 1'b1; cs_v = 1'b1;
    m0_r = 1'b1; m1_r = 1'b1;
    s0_d = 64'h0; s1_d = 64'h0; cs_d = 64'h0;
    @(negedge clk); #1;
    step();
    chk("rst_cm_v", cm_v, 0);
    chk("rst_s0_r", s0_r, 0);
    chk("rst_s1_r", s1_r, 0);
    chk("rst_cs_r", cs_r, 0);
    chk("rst_m0_v", m0_v, 0);
    chk("rst_m1_v", m1_v, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_orph", orphan, 0);
    step();

    // Tie: both valid, core ready -> 0,1,0,1
    rst_n = 1'b1; cs_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s0_d = 64'hA000_0000_0000_0000 | 64'(k);
      s1_d = 64'hB000_0000_0000_0000 | 64'(k);
      #1;
      chk("tie_data", cm_d, (k % 2 == 0) ? s0_d : s1_d);
      chk("tie_s0r", s0_r, (k % 2 == 0) ? 1 : 0);
      chk("tie_s1r", s1_r, (k % 2 == 0) ? 0 : 1);
      step();
    end
    chk("full_cnt", cnt, 4);
    // Full with a pop in the same cycle: no bypass
    cs_v = 1'b1; cs_d = 64'hC0;
    #1;
    chk("full_cm_v", cm_v, 0);
    chk("full_s0_r", s0_r, 0);
    chk("ret0_m0v", m0_v, 1);
    chk("ret0_m1v", m1_v, 0);
    chk("ret0_data", m0_d, 64'hC0);
    chk("ret0_csr", cs_r, 1);
    step();
    chk("pop_cnt", cnt, 3);
    s0_v = 1'b0; s1_v = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cs_d = 64'hC0 + 64'(k);
      #1;
      chk("ret_m0v", m0_v, (k % 2 == 0) ? 1 : 0);
      chk("ret_m1v", m1_v, (k % 2 == 0) ? 0 : 1);
      chk("ret_data", (k % 2 == 0) ? m0_d : m1_d, 64'hC0 + 64'(k));
      step();
    end
    cs_v = 1'b0;
    #1;
    chk("drain_cnt", cnt, 0);

    // Stall: s0 wins, core not ready for 5 cycles
    s0_v = 1'b1; s1_v = 1'b1; cm_r = 1'b0;
    s0_d = 64'h5050; s1_d = 64'h5151;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_v", cm_v, 1);
      chk("stall_data", cm_d, 64'h5050);
      chk("stall_s0r", s0_r, 0);
      step();
    end
    cm_r = 1'b1;
    #1;
    chk("stall_acc", s0_r, 1);
    chk("stall_s1r", s1_r, 0);
    step();

    // Lock must hold s0 even when a tie would favour s1
    s1_v = 1'b0; cm_r = 1'b0; s0_d = 64'h5252;
    #1;
    chk("lock_data0", cm_d, 64'h5252);
    step();
    s1_v = 1'b1;
    #1;
    chk("lock_data1", cm_d, 64'h5252);
    step();
    cm_r = 1'b1;
    #1;
    chk("lock_s0r", s0_r, 1);
    chk("lock_s1r", s1_r, 0);
    step();
    #1;
    chk("after_data", cm_d, 64'h5151);
    chk("after_s1r", s1_r, 1);
    step();
    s0_v = 1'b0; s1_v = 1'b0;
    chk("lock_cnt", cnt, 3);
    cs_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lk_m1v", m1_v, (k == 2) ? 1 : 0);
      step();
    end
    cs_v = 1'b0;
    #1;
    chk("lk_cnt", cnt, 0);

    // Full: requesters not ready to take results
    m0_r = 1'b0; m1_r = 1'b0; s0_v = 1'b1; s0_d = 64'h4444;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_s0r", s0_r, 1);
      step();
    end
    chk("f_cnt", cnt, 4);
    chk("f_s0r", s0_r, 0);
    chk("f_cmv", cm_v, 0);
    cs_v = 1'b1;
    #1;
    chk("f_csr", cs_r, 0);
    chk("f_m0v", m0_v, 1);
    step();
    m0_r = 1'b1;
    #1;
    chk("f_csr1", cs_r, 1);
    chk("f_nobyp", s0_r, 0);
    step();
    chk("f_cnt3", cnt, 3);
    m0_r = 1'b0; cs_v = 1'b0;
    #1;
    chk("f_reissue", s0_r, 1);
    chk("f_reissv", cm_v, 1);
    step();
    chk("f_cnt4", cnt, 4);
    s0_v = 1'b0; m0_r = 1'b1; cs_v = 1'b1;
    for (int k = 0; k < 4; k++) step();
    cs_v = 1'b0;
    #1;
    chk("f_drain", cnt, 0);

    // Head blocking: issue 0 then 1
    s0_v = 1'b1;
    step();
    s0_v = 1'b0; s1_v = 1'b1;
    step();
    s1_v = 1'b0;
    chk("hb_cnt", cnt, 2);
    m0_r = 1'b0; m1_r = 1'b1; cs_v = 1'b1; cs_d = 64'h7777;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("hb_csr", cs_r, 0);
      chk("hb_m1v", m1_v, 0);
      chk("hb_m0v", m0_v, 1);
      step();
    end
    m0_r = 1'b1;
    #1;
    chk("hb_go", cs_r, 1);
    step();
    chk("hb_m1v2", m1_v, 1);
    chk("hb_m0v2", m0_v, 0);
    chk("hb_csr2", cs_r, 1);
    step();
    cs_v = 1'b0;
    #1;
    chk("hb_cnt0", cnt, 0);

    // Orphan result on an empty FIFO
    cs_v = 1'b1;
    #1;
    chk("orp_csr", cs_r, 1);
    chk("orp_m0v", m0_v, 0);
    chk("orp_m1v", m1_v, 0);
    chk("orp_pre", orphan, 0);
    step();
    cs_v = 1'b0;
    chk("orp_set", orphan, 1);
    step(); step(); step();
    chk("orp_stky", orphan, 1);
    chk("orp_cnt", cnt, 0);
    rst_n = 1'b0;
    step();
    chk("orp_clr", orphan, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
